// File: rtl/matrix2_7_cfg_loader_pkg.sv
// Shared constants and types for the switch-matrix config loader.
// Holds tile geometry, side codes, frame constants and the FSM state type.
package matrix2_7_cfg_loader_pkg;

    localparam int NTB    = 5;
    localparam int NLR    = 4;
    localparam int DW     = 6;
    localparam int NENT   = 2 * NTB + 2 * NLR;
    localparam int WORD_W = NENT * DW;
    localparam int CS_W   = 8;

    localparam logic [7:0] SYNC = 8'hA5;

    localparam logic [2:0] SIDE_OFF    = 3'd0;
    localparam logic [2:0] SIDE_TOP    = 3'd1;
    localparam logic [2:0] SIDE_RIGHT  = 3'd2;
    localparam logic [2:0] SIDE_BOTTOM = 3'd3;
    localparam logic [2:0] SIDE_LEFT   = 3'd4;

    localparam int TOP_BASE   = 0;
    localparam int BOT_BASE   = 5;
    localparam int LEFT_BASE  = 10;
    localparam int RIGHT_BASE = 14;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_LOAD,
        ST_CSUM,
        ST_CHECK
    } state_t;

    function automatic logic [CS_W-1:0] entry_ext(input logic [DW-1:0] e);
        return {{(CS_W-DW){1'b0}}, e};
    endfunction

endpackage

// File: rtl/matrix2_7_cfg_loader_if.sv
// Serial config bus between the chip config chain and one tile loader.
// master: drives cfg_valid/cfg_bit/cfg_abort; slave: drives word and status.
interface matrix2_7_cfg_loader_if;
    import matrix2_7_cfg_loader_pkg::*;

    logic              cfg_valid;
    logic              cfg_bit;
    logic              cfg_abort;
    logic [WORD_W-1:0] cfg_word;
    logic              cfg_commit;
    logic              cfg_error;
    logic              cfg_busy;
    logic              cfg_loaded;

    modport master (
        output cfg_valid, cfg_bit, cfg_abort,
        input  cfg_word, cfg_commit, cfg_error, cfg_busy, cfg_loaded
    );

    modport slave (
        input  cfg_valid, cfg_bit, cfg_abort,
        output cfg_word, cfg_commit, cfg_error, cfg_busy, cfg_loaded
    );

endinterface

// File: rtl/matrix2_7_cfg_loader_entry_check.sv
// Combinational legality check of one route-select entry.
// Ports: entry_i (DW-bit entry), num_i (entry number), bad_o (illegal).
module matrix2_7_cfg_loader_entry_check
    import matrix2_7_cfg_loader_pkg::*;
(
    input  logic [DW-1:0] entry_i,
    input  logic [4:0]    num_i,
    output logic          bad_o
);

    localparam logic [2:0] NTB_IDX = 3'(NTB);
    localparam logic [2:0] NLR_IDX = 3'(NLR);
    localparam logic [4:0] NENT_N  = 5'(NENT);

    logic [2:0] side;
    logic [2:0] idx;

    assign side = entry_i[2:0];
    assign idx  = entry_i[5:3];

    always_comb begin
        bad_o = 1'b0;
        case (side)
            SIDE_OFF:               bad_o = 1'b0;
            SIDE_TOP, SIDE_BOTTOM:  bad_o = (idx >= NTB_IDX);
            SIDE_RIGHT, SIDE_LEFT:  bad_o = (idx >= NLR_IDX);
            default:                bad_o = 1'b1;
        endcase
        // Entry numbers past the last wire never map to a tile input.
        if (num_i >= NENT_N) begin
            bad_o = 1'b1;
        end
    end

endmodule

// File: rtl/matrix2_7_cfg_loader.sv
// Framed serial config writer for the 5x4 switch-matrix tile.
// Ports: clk, rst (sync, active-high), bus (slave: serial in, word/status out).
module matrix2_7_cfg_loader
    import matrix2_7_cfg_loader_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    matrix2_7_cfg_loader_if.slave        bus
);

    localparam logic [6:0] LAST_BIT = 7'(WORD_W - 1);
    localparam logic [2:0] LAST_POS = 3'(DW - 1);
    localparam logic [6:0] LAST_CS  = 7'(CS_W - 1);

    state_t            state_q, state_d;
    logic [7:0]        sh_q, sh_d;
    logic [DW-2:0]     ent_q, ent_d;
    logic [2:0]        pos_q, pos_d;
    logic [4:0]        num_q, num_d;
    logic [6:0]        bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] stage_q, stage_d;
    logic [CS_W-1:0]   sum_q, sum_d;
    logic [CS_W-1:0]   csum_q, csum_d;
    logic              bad_q, bad_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              commit_q, commit_d;
    logic              error_q, error_d;
    logic              loaded_q, loaded_d;

    logic [DW-1:0]     new_ent;
    logic              ent_bad;

    assign new_ent = {ent_q, bus.cfg_bit};

    matrix2_7_cfg_loader_entry_check u_chk (
        .entry_i (new_ent),
        .num_i   (num_q),
        .bad_o   (ent_bad)
    );

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        ent_d     = ent_q;
        pos_d     = pos_q;
        num_d     = num_q;
        bit_cnt_d = bit_cnt_q;
        stage_d   = stage_q;
        sum_d     = sum_q;
        csum_d    = csum_q;
        bad_d     = bad_q;
        word_d    = word_q;
        commit_d  = 1'b0;
        error_d   = 1'b0;
        loaded_d  = loaded_q;

        if (bus.cfg_abort) begin
            state_d = ST_HUNT;
            sh_d    = '0;
        end else begin
            unique case (state_q)
                ST_HUNT: begin
                    if (bus.cfg_valid) begin
                        sh_d = {sh_q[6:0], bus.cfg_bit};
                        // Compare the updated window so the next bit
                        // is already the first payload bit.
                        if (sh_d == SYNC) begin
                            state_d   = ST_LOAD;
                            bit_cnt_d = '0;
                            sum_d     = '0;
                            pos_d     = '0;
                            num_d     = '0;
                            ent_d     = '0;
                            bad_d     = 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (bus.cfg_valid) begin
                        if (bit_cnt_q != LAST_BIT) begin
                            bit_cnt_d = bit_cnt_q + 7'd1;
                        end
                        if (pos_q == LAST_POS) begin
                            // First entry received ends up in the low slot.
                            stage_d = {new_ent, stage_q[WORD_W-1:DW]};
                            sum_d   = sum_q + entry_ext(new_ent);
                            bad_d   = bad_q | ent_bad;
                            num_d   = num_q + 5'd1;
                            pos_d   = '0;
                            ent_d   = '0;
                        end else begin
                            pos_d = pos_q + 3'd1;
                            ent_d = new_ent[DW-2:0];
                        end
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d   = ST_CSUM;
                            bit_cnt_d = '0;
                        end
                    end
                end
                ST_CSUM: begin
                    if (bus.cfg_valid) begin
                        csum_d    = {csum_q[CS_W-2:0], bus.cfg_bit};
                        bit_cnt_d = bit_cnt_q + 7'd1;
                        if (bit_cnt_q == LAST_CS) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    state_d = ST_HUNT;
                    sh_d    = '0;
                    if ((csum_q == sum_q) && !bad_q) begin
                        word_d   = stage_q;
                        commit_d = 1'b1;
                        loaded_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    sh_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_HUNT;
            sh_q      <= '0;
            ent_q     <= '0;
            pos_q     <= '0;
            num_q     <= '0;
            bit_cnt_q <= '0;
            stage_q   <= '0;
            sum_q     <= '0;
            csum_q    <= '0;
            bad_q     <= 1'b0;
            word_q    <= '0;
            commit_q  <= 1'b0;
            error_q   <= 1'b0;
            loaded_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            ent_q     <= ent_d;
            pos_q     <= pos_d;
            num_q     <= num_d;
            bit_cnt_q <= bit_cnt_d;
            stage_q   <= stage_d;
            sum_q     <= sum_d;
            csum_q    <= csum_d;
            bad_q     <= bad_d;
            word_q    <= word_d;
            commit_q  <= commit_d;
            error_q   <= error_d;
            loaded_q  <= loaded_d;
        end
    end

    assign bus.cfg_word   = word_q;
    assign bus.cfg_commit = commit_q;
    assign bus.cfg_error  = error_q;
    assign bus.cfg_busy   = (state_q != ST_HUNT);
    assign bus.cfg_loaded = loaded_q;

endmodule

// File: tb/tb_matrix2_7_cfg_loader.sv
// Self-checking bench for matrix2_7_cfg_loader.
// Table of directed frames plus hand-written abort/reset/sync/latency cases.
module tb_matrix2_7_cfg_loader;
    import matrix2_7_cfg_loader_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix2_7_cfg_loader_if bus();

    matrix2_7_cfg_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [107:0] w;
        logic [7:0]   cs;
        bit           gaps;
        int           ec;
        int           ee;
        logic [107:0] ew;
    } vec_t;

    vec_t vt[12];

    int errors = 0;
    int checks = 0;
    int n_commit = 0;
    int n_error = 0;
    int busy_bad = 0;
    bit busy_mon = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (bus.cfg_commit === 1'b1) n_commit++;
        if (bus.cfg_error === 1'b1) n_error++;
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            bus.cfg_valid = 1'b0;
            bus.cfg_bit   = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic send_bit(input logic b, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 1)) begin
                bus.cfg_valid = 1'b0;
                @(negedge clk);
                if (busy_mon && bus.cfg_busy !== 1'b1) busy_bad++;
            end
        end
        bus.cfg_valid = 1'b1;
        bus.cfg_bit   = b;
        @(negedge clk);
        if (busy_mon && bus.cfg_busy !== 1'b1) busy_bad++;
        bus.cfg_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gaps);
        for (int i = 7; i >= 0; i--) send_bit(v[i], gaps);
    endtask

    task automatic send_load(input logic [107:0] w, input int n,
                             input bit gaps);
        for (int i = 0; i < n; i++) begin
            send_bit(w[(i / 6) * 6 + 5 - (i % 6)], gaps);
        end
    endtask

    task automatic send_frame(input logic [107:0] w, input logic [7:0] cs,
                              input bit gaps);
        busy_bad = 0;
        busy_mon = 1'b0;
        send_byte(SYNC, gaps);
        busy_mon = 1'b1;
        send_load(w, 108, gaps);
        send_byte(cs, gaps);
        busy_mon = 1'b0;
    endtask

    initial begin
        int c0;
        int e0;

        vt[0]  = '{108'h0A, 8'h0A, 1'b0, 1, 0, 108'h0A};
        vt[1]  = '{108'h0A, 8'h0B, 1'b0, 0, 1, 108'h0A};
        vt[2]  = '{108'h2B << 72, 8'h2B, 1'b0, 0, 1, 108'h0A};
        vt[3]  = '{108'h05, 8'h05, 1'b0, 0, 1, 108'h0A};
        vt[4]  = '{108'h0A, 8'h0A, 1'b1, 1, 0, 108'h0A};
        vt[5]  = '{108'h22 << 6, 8'h22, 1'b0, 0, 1, 108'h0A};
        vt[6]  = '{(108'h21 << 30) | (108'h1C << 78), 8'h3D, 1'b0, 1, 0,
                   (108'h21 << 30) | (108'h1C << 78)};
        vt[7]  = '{{18{6'h21}}, 8'h52, 1'b0, 1, 0, {18{6'h21}}};
        vt[8]  = '{108'h38, 8'h38, 1'b0, 1, 0, 108'h38};
        vt[9]  = '{(108'h19 << 102) | 108'h0A, 8'h23, 1'b1, 1, 0,
                   (108'h19 << 102) | 108'h0A};
        vt[10] = '{108'h01, 8'h01, 1'b0, 1, 0, 108'h01};
        vt[11] = '{{18{6'h21}}, 8'h53, 1'b0, 0, 1, 108'h01};

        rst           = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_bit   = 1'b0;
        bus.cfg_abort = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_word", 128'(bus.cfg_word), 128'h0);
        chk("rst_commit", 128'(bus.cfg_commit), 128'h0);
        chk("rst_error", 128'(bus.cfg_error), 128'h0);
        chk("rst_busy", 128'(bus.cfg_busy), 128'h0);
        chk("rst_loaded", 128'(bus.cfg_loaded), 128'h0);

        for (int i = 0; i < 12; i++) begin
            c0 = n_commit;
            e0 = n_error;
            send_frame(vt[i].w, vt[i].cs, vt[i].gaps);
            idle(3);
            chk($sformatf("v%0d_commit", i), 128'(n_commit - c0),
                128'(vt[i].ec));
            chk($sformatf("v%0d_error", i), 128'(n_error - e0),
                128'(vt[i].ee));
            chk($sformatf("v%0d_word", i), 128'(bus.cfg_word),
                128'(vt[i].ew));
            chk($sformatf("v%0d_loaded", i), 128'(bus.cfg_loaded), 128'h1);
            chk($sformatf("v%0d_busy", i), 128'(busy_bad), 128'h0);
        end

        // Commit latency: CHECK cycle first, pulse one cycle later.
        send_frame(108'h0A, 8'h0A, 1'b0);
        chk("lat_chk_commit", 128'(bus.cfg_commit), 128'h0);
        chk("lat_chk_busy", 128'(bus.cfg_busy), 128'h1);
        @(negedge clk);
        chk("lat_commit", 128'(bus.cfg_commit), 128'h1);
        chk("lat_busy", 128'(bus.cfg_busy), 128'h0);
        chk("lat_word", 128'(bus.cfg_word), 128'h0A);
        @(negedge clk);
        chk("lat_pulse_end", 128'(bus.cfg_commit), 128'h0);
        idle(2);

        // Abort at bit 60 with a valid bit in the same cycle.
        c0 = n_commit;
        e0 = n_error;
        send_byte(SYNC, 1'b0);
        send_load(108'h0, 60, 1'b0);
        bus.cfg_abort = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_bit   = 1'b1;
        @(negedge clk);
        bus.cfg_abort = 1'b0;
        bus.cfg_valid = 1'b0;
        chk("abort_busy", 128'(bus.cfg_busy), 128'h0);
        send_frame(vt[9].w, vt[9].cs, 1'b0);
        idle(3);
        chk("abort_commit", 128'(n_commit - c0), 128'h1);
        chk("abort_error", 128'(n_error - e0), 128'h0);
        chk("abort_word", 128'(bus.cfg_word), 128'(vt[9].ew));

        // Reset at bit 60 clears the committed word and loaded flag.
        c0 = n_commit;
        e0 = n_error;
        send_byte(SYNC, 1'b0);
        send_load(108'h0, 60, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        chk("rst60_word", 128'(bus.cfg_word), 128'h0);
        chk("rst60_loaded", 128'(bus.cfg_loaded), 128'h0);
        chk("rst60_busy", 128'(bus.cfg_busy), 128'h0);
        chk("rst60_pulses", 128'((n_commit - c0) + (n_error - e0)), 128'h0);

        // Near-miss noise before the real sync word.
        c0 = n_commit;
        e0 = n_error;
        send_byte(8'h5A, 1'b0);
        send_byte(8'hA4, 1'b0);
        send_frame(vt[6].w, vt[6].cs, 1'b0);
        idle(3);
        chk("noise_commit", 128'(n_commit - c0), 128'h1);
        chk("noise_error", 128'(n_error - e0), 128'h0);
        chk("noise_word", 128'(bus.cfg_word), 128'(vt[6].ew));
        chk("noise_loaded", 128'(bus.cfg_loaded), 128'h1);

        // Two good frames in a row, second one wins.
        c0 = n_commit;
        e0 = n_error;
        send_frame(108'h0A, 8'h0A, 1'b0);
        idle(2);
        send_frame({18{6'h21}}, 8'h52, 1'b0);
        idle(3);
        chk("b2b_commit", 128'(n_commit - c0), 128'h2);
        chk("b2b_error", 128'(n_error - e0), 128'h0);
        chk("b2b_word", 128'(bus.cfg_word), 128'({18{6'h21}}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
